// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared constants, font lookup and FSM state type for the 7-segment display driver
package seg_pkg;

    localparam int BCD_DIGITS = 10;

    // Active-low segments ordered {dp,g,f,e,d,c,b,a}; dp stays off
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    typedef enum logic {IDLE, CONV} conv_state_e;

    function automatic logic [7:0] seg_font(input logic [3:0] d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/seg_disp_driver_if.sv
// rtl/seg_disp_driver_if.sv - value input strobe and display/status outputs of the display driver
interface seg_disp_driver_if #(
    parameter int DIGITS = 8
);
    logic [31:0]       data_in;
    logic              data_valid;
    logic [DIGITS-1:0] seg_sel;
    logic [7:0]        seg_led;
    logic              busy;
    logic              conv_done;
    logic              overflow;

    modport master (
        output data_in, data_valid,
        input  seg_sel, seg_led, busy, conv_done, overflow
    );

    modport slave (
        input  data_in, data_valid,
        output seg_sel, seg_led, busy, conv_done, overflow
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential 32-bit to 10-digit BCD double dabble; start during a conversion restarts it
module bin2bcd_seq
    import seg_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [31:0]             bin_in,
    output logic                    busy,
    output logic                    done,
    output logic [4*BCD_DIGITS-1:0] bcd
);

    conv_state_e             state_q, state_d;
    logic [31:0]             bin_q;
    logic [5:0]              iter_q;
    logic [4*BCD_DIGITS-1:0] adj;
    logic                    load, step;

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = CONV;
                end
            end
            CONV: begin
                if (iter_q == 6'd32) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end else begin
                    step = 1'b1;
                end
                // A new start wins; done still fires so the finished result is committed
                if (start) begin
                    load    = 1'b1;
                    step    = 1'b0;
                    state_d = CONV;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        adj = bcd;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            bin_q   <= '0;
            bcd     <= '0;
            iter_q  <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                bin_q  <= bin_in;
                bcd    <= '0;
                iter_q <= '0;
            end else if (step) begin
                {bcd, bin_q} <= {adj, bin_q} << 1;
                iter_q       <= iter_q + 6'd1;
            end
        end
    end

    assign busy = (state_q == CONV);

endmodule

// File: rtl/seg_disp_driver.sv
// rtl/seg_disp_driver.sv - BCD conversion plus multiplexed active-low 7-segment scan; SEG_LEADING_ZERO_BLANK_EN blanks leading zeros
module seg_disp_driver
    import seg_pkg::*;
#(
    parameter int DIGITS   = 8,
    parameter int SCAN_DIV = 50000
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    seg_disp_driver_if.slave  bus
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CNT_W = $clog2(SCAN_DIV);

    logic                    conv_fin;
    logic [4*BCD_DIGITS-1:0] bcd;
    logic [4*DIGITS-1:0]     disp_q;
    logic [IDX_W-1:0]        idx_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [3:0]              cur_digit;
    logic                    blank;

    bin2bcd_seq u_conv (
        .clk    (sys_clk),
        .rst_n  (sys_rst_n),
        .start  (bus.data_valid),
        .bin_in (bus.data_in),
        .busy   (bus.busy),
        .done   (conv_fin),
        .bcd    (bcd)
    );

    always_comb begin
        cur_digit = disp_q[{idx_q, 2'b00} +: 4];
`ifdef SEG_LEADING_ZERO_BLANK_EN
        // Blank when this and every higher digit are zero; digit 0 always shows
        blank = (idx_q != '0) && ((disp_q >> {idx_q, 2'b00}) == '0);
`else
        blank = 1'b0;
`endif
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            disp_q        <= '0;
            idx_q         <= '0;
            cnt_q         <= '0;
            bus.conv_done <= 1'b0;
            bus.overflow  <= 1'b0;
            bus.seg_sel   <= '1;
            bus.seg_led   <= SEG_BLANK;
        end else begin
            bus.conv_done <= conv_fin;
            if (conv_fin) begin
                disp_q       <= bcd[4*DIGITS-1:0];
                bus.overflow <= |bcd[4*BCD_DIGITS-1:4*DIGITS];
            end
            if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
                cnt_q <= '0;
                idx_q <= (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
            bus.seg_sel <= ~(DIGITS'(1) << idx_q);
            bus.seg_led <= blank ? SEG_BLANK : seg_font(cur_digit);
        end
    end

endmodule

// File: tb/tb_seg_disp_driver.sv
// tb/tb_seg_disp_driver.sv - randomized bench for seg_disp_driver against a decimal-arithmetic reference model
module tb_seg_disp_driver;

    localparam int DIGITS   = 8;
    localparam int SCAN_DIV = 4;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;
    int   edge_n;

    // Reference model state: plain decimal values and cycle numbers
    bit     pend;
    longint pend_val;
    int     pend_due;
    longint m_disp;
    bit     m_ovf;
    bit     m_done;
    int     scan_cnt;
    int     scan_idx;

    logic [7:0] font_tbl [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                  8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    seg_disp_driver_if #(.DIGITS(DIGITS)) dif ();

    seg_disp_driver #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .bus       (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic longint pow10(input int n);
        longint r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [7:0] exp_led(input longint v, input int i);
        longint d = (v / pow10(i)) % 10;
`ifdef SEG_LEADING_ZERO_BLANK_EN
        if (i > 0 && v < pow10(i)) return 8'hFF;
`endif
        return font_tbl[d];
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at edge %0d", tag, obs, exp, edge_n);
        end
    endtask

    task automatic tick();
        logic [DIGITS-1:0] e_sel;
        logic [7:0]        e_led;
        @(posedge clk);
        edge_n++;
        if (!rst_n) begin
            pend     = 0;
            m_disp   = 0;
            m_ovf    = 0;
            m_done   = 0;
            scan_cnt = 0;
            scan_idx = 0;
            e_sel    = '1;
            e_led    = 8'hFF;
        end else begin
            e_sel = ~(DIGITS'(1) << scan_idx);
            e_led = exp_led(m_disp, scan_idx);
            if (scan_cnt == SCAN_DIV - 1) begin
                scan_cnt = 0;
                scan_idx = (scan_idx + 1) % DIGITS;
            end else begin
                scan_cnt++;
            end
            m_done = pend && (pend_due == edge_n);
            if (m_done) begin
                m_disp = pend_val % pow10(DIGITS);
                m_ovf  = (pend_val >= pow10(DIGITS));
                pend   = 0;
            end
            if (dif.data_valid) begin
                pend     = 1;
                pend_val = longint'(dif.data_in);
                pend_due = edge_n + 33;
            end
        end
        #1;
        check_eq("seg_sel",   32'(dif.seg_sel), 32'(e_sel));
        check_eq("seg_led",   32'(dif.seg_led), 32'(e_led));
        check_eq("busy",      32'(dif.busy),      32'(pend));
        check_eq("conv_done", 32'(dif.conv_done), 32'(m_done));
        check_eq("overflow",  32'(dif.overflow),  32'(m_ovf));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse(input logic [31:0] v);
        dif.data_in    = v;
        dif.data_valid = 1'b1;
        tick();
        dif.data_valid = 1'b0;
        dif.data_in    = $urandom;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish at edge %0d", edge_n);
        $fatal(1, "watchdog");
    end

    initial begin
        int gap;
        logic [31:0] v;
        n_cmp = 0;
        n_err = 0;
        edge_n = 0;
        rst_n = 1'b0;
        dif.data_in = '0;
        dif.data_valid = 1'b0;
        run(3);
        rst_n = 1'b1;
        run(40);

        pulse(32'd12345678);
        run(75);
        pulse(32'hFFFFFFFF);
        run(75);
        pulse(32'd11111111);
        run(9);
        pulse(32'd87654321);
        run(75);
        pulse(32'd42);
        run(75);
        pulse(32'd0);
        run(75);

        pulse(32'd99999999);
        run(15);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        run(60);

        for (int k = 0; k < 40; k++) begin
            v = $urandom >> $urandom_range(0, 31);
            gap = (k == 5 || k == 6) ? 33 : $urandom_range(1, 50);
            pulse(v);
            run(gap - 1);
        end
        run(75);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
